// File: rtl/serial_pkg.sv
// Shared types and widths for the 4-bit serial transmitter.
// SERIAL_TX_PARITY_EN adds the PARITY state to the state encoding.
package serial_pkg;

   localparam int unsigned DATA_W = 4;
   localparam int unsigned CNT_W  = 2;

   localparam logic [CNT_W-1:0] CNT_LAST = '1;

`ifdef SERIAL_TX_PARITY_EN
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_t;
`else
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;
`endif

endpackage

// File: rtl/piso_reg_4bit.sv
// 4-bit parallel-load, left-shifting register with zero fill.
// Load takes priority over shift; only the MSB is exported.
module piso_reg_4bit
   import serial_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              shift,
   input  logic [DATA_W-1:0] din,
   output logic              q_msb
);

   logic [DATA_W-1:0] sr_q;
   logic [DATA_W-1:0] sr_d;

   always_comb begin
      sr_d = sr_q;
      if (load) begin
         sr_d = din;
      end else if (shift) begin
         sr_d = {sr_q[DATA_W-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign q_msb = sr_q[DATA_W-1];

endmodule

// File: rtl/serial_tx_4bit.sv
// 4-bit MSB-first serializer with load handshake and en-qualified bit timing.
// Define SERIAL_TX_PARITY_EN to append an even-parity bit to each frame.
module serial_tx_4bit
   import serial_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [DATA_W-1:0] din,
   input  logic              load_valid,
   output logic              load_ready,
   output logic              Q,
   output logic              frame,
   output logic              done
);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              done_q, done_d;
   logic              load;
   logic              shift;
   logic              sr_msb;
`ifdef SERIAL_TX_PARITY_EN
   logic              par_q, par_d;
`endif

   assign load_ready = (state_q == IDLE);
   assign load       = load_valid & load_ready;
   assign shift      = (state_q == SHIFT) & en;

   piso_reg_4bit u_piso (
      .clk   (clk),
      .rst_n (rst),
      .load  (load),
      .shift (shift),
      .din   (din),
      .q_msb (sr_msb)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         IDLE: begin
            if (load_valid) begin
               state_d = SHIFT;
               cnt_d   = '0;
`ifdef SERIAL_TX_PARITY_EN
               par_d   = ^din;
`endif
            end
         end
         SHIFT: begin
            if (en) begin
               cnt_d = cnt_q + 1'b1;
               // last data bit consumed: counter wraps to 0 exactly as the frame ends
               if (cnt_q == CNT_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = IDLE;
                  done_d  = 1'b1;
`endif
               end
            end
         end
`ifdef SERIAL_TX_PARITY_EN
         PARITY: begin
            if (en) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
`ifdef SERIAL_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   always_comb begin
      Q     = 1'b0;
      frame = 1'b0;
      case (state_q)
         SHIFT: begin
            Q     = sr_msb;
            frame = 1'b1;
         end
`ifdef SERIAL_TX_PARITY_EN
         PARITY: begin
            Q     = par_q;
            frame = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   assign done = done_q;

endmodule
